maxpool_scheduler: RTL
======================

# maxpool_scheduler

Sequences a multi-channel feature map, stored channel-planar in memory, through one streaming 2x2/stride-2 max-pool unit. One channel is processed at a time, and the pool unit is cleared between channels. The block generates read addresses and the pool's pixel-valid strobe, predicts which cycles carry a pooled result, and writes those results back at packed output addresses. It sits between the layer sequencer (start/done) and the feature-map SRAM plus the pool datapath.

## Interface
Parameters:
- DATA_WIDTH, 32, pixel width
- IMG_SIZE, 100, input plane edge; must be even
- MAX_CH, 64, maximum channel count
- ADDR_WIDTH, 20, memory word address width
- WR_LAT, 1, cycles from the pool-valid strobe of a window's last pixel to its result being stable on pool_data_out

Ports:
- Clk  in  1  single clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- num_ch  in  $clog2(MAX_CH+1)  channel count, latched at start; 0 means done immediately
- in_base  in  ADDR_WIDTH  input plane 0 base, latched at start
- out_base  in  ADDR_WIDTH  output plane 0 base, latched at start
- hold  in  1  memory arbitration stall; no read is issued while high
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at completion
- rd_en  out  1  SRAM read strobe
- rd_addr  out  ADDR_WIDTH  read address
- rd_data  in  DATA_WIDTH  read data, valid 1 cycle after rd_en
- pool_valid_in  out  1  pixel strobe to the pool unit
- pool_data_in  out  DATA_WIDTH  pixel to the pool unit (registered rd_data)
- pool_clr  out  1  active-high clear to the pool unit
- pool_data_out  in  DATA_WIDTH  pooled result from the pool unit
- wr_en  out  1  SRAM write strobe
- wr_addr  out  ADDR_WIDTH  write address
- wr_data  out  DATA_WIDTH  write data

## Operation
- **FSM states:** IDLE, CLEAR, STREAM, DRAIN, NEXT, DONE.
- **IDLE:**
  - On start with num_ch≠0: latch config, ch=0, go to CLEAR.
  - On start with num_ch=0: go to DONE.
- **CLEAR:** pool_clr=1 for exactly 1 cycle; reset row/col counters to 0; go to STREAM.
- **STREAM:**
  - Each cycle with hold=0: rd_en=1, rd_addr = in_base + ch·IMG_SIZE² + row·IMG_SIZE + col; then advance col, wrapping to 0 and incrementing row.
  - With hold=1: rd_en=0, counters frozen.
  - After pixel (IMG_SIZE-1, IMG_SIZE-1) is issued, go to DRAIN.
- **Pool feed:** pool_valid_in is rd_en delayed 1 cycle; pool_data_in = rd_data registered alongside it.
- **Write prediction:**
  - A window completes on a pixel with row odd and col odd.
  - WR_LAT cycles after that pixel's pool_valid_in cycle: wr_en=1, wr_data=pool_data_out, wr_addr = out_base + ch·(IMG_SIZE/2)² + oidx.
  - oidx counts 0..(IMG_SIZE/2)²-1 in raster order.
  - A delay line (depth 1+WR_LAT) carries the completion flag; the pool unit's own valid output is not used.
- **DRAIN:** wait until the delay line is empty (last write issued); go to NEXT.
- **NEXT:** ch+1. If ch+1 = num_ch go to DONE, else go to CLEAR.
- **DONE:** done=1 for 1 cycle, busy=0; go to IDLE.
- **Address arithmetic:** ADDR_WIDTH, wraps modulo 2^ADDR_WIDTH. Plane offsets are accumulated by adding a constant plane stride per channel; no multiplier.

## Timing
- **Reset:** all outputs 0; FSM=IDLE; counters 0. Assertion mid-operation aborts immediately; no done pulse.
- **Read-to-pool latency:** 1 cycle from rd_en to pool_valid_in.
- **Per-channel cycles with hold=0:** 1 (CLEAR) + IMG_SIZE² (STREAM) + 1+WR_LAT (DRAIN) + 1 (NEXT).
- **Hold:** affects reads only. Pipelined pool_valid_in and wr_en already in flight still complete. hold in DRAIN/CLEAR/NEXT is ignored.
- **start:** ignored while busy. start coincident with done is ignored.
- **Config inputs:** changes after the start cycle have no effect.
- **Counts per channel:** exactly (IMG_SIZE/2)² writes; wr_en never asserted outside STREAM/DRAIN.

## Structure
- **Shared package** (`pool_pkg`): FSM state enum, `plane_words(IMG_SIZE)` and `out_plane_words` constant functions, CH_W width.
- **Sub-module:** `raster_counter` (row/col with enable, clear, last flag, odd-odd flag), reusable by other layer schedulers.
- **Top:** FSM, address accumulators, and completion delay line live here.

## Test plan
- **Single channel:** IMG_SIZE=4, num_ch=1, SRAM holds 0..15, hold=0 → writes 5,7,13,15 to out_base+0..3; done 1+16+2+1+1 cycles after busy rises.
- **Multi-channel:** num_ch=3 → 3 pool_clr pulses; writes at out_base+{0..3,4..7,8..11}; reads span in_base..in_base+47.
- **Random hold:** 30% random hold → same write data and addresses as the no-hold run; rd_en=0 whenever hold=1.
- **Zero channels:** num_ch=0 → done 2 cycles after start; no rd_en, wr_en, or pool_clr.
- **Reset mid-stream:** Rst low during channel 1 → all outputs 0 asynchronously; a fresh start afterwards completes correctly.
- **Start while busy:** second start while busy, and address wrap near 2^ADDR_WIDTH → second start ignored; addresses wrap modulo.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and geometry helpers for the pooling layer schedulers.
package pool_pkg;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_NEXT,
        ST_DONE
    } state_t;

    // Width of a channel count that must hold 0..max_ch inclusive.
    function automatic int unsigned ch_width(input int unsigned max_ch);
        return $clog2(max_ch + 1);
    endfunction

    // Words in one input plane.
    function automatic int unsigned plane_words(input int unsigned img);
        return img * img;
    endfunction

    // Words in one 2x2/stride-2 pooled output plane.
    function automatic int unsigned out_plane_words(input int unsigned img);
        return (img / 2) * (img / 2);
    endfunction

    localparam int unsigned DEF_MAX_CH = 64;
    localparam int unsigned CH_W       = ch_width(DEF_MAX_CH);

endpackage

// File: rtl/raster_counter.sv
// Row/column raster walker over a SIZE x SIZE plane with window-corner flags.
module raster_counter #(
    parameter int unsigned SIZE = 100,
    parameter int unsigned W    = $clog2(SIZE)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] row,
    output logic [W-1:0] col,
    output logic         last,
    output logic         odd_odd
);

    localparam logic [W-1:0] MAXV = W'(SIZE - 1);

    // Advance col each enabled cycle, wrapping into the next row; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (col == MAXV) begin
                col <= '0;
                row <= (row == MAXV) ? '0 : row + W'(1);
            end else begin
                col <= col + W'(1);
            end
        end
    end

    assign last    = (row == MAXV) && (col == MAXV);
    assign odd_odd = row[0] & col[0];

endmodule

// File: rtl/maxpool_scheduler.sv
// Channel-by-channel sequencer feeding a streaming 2x2/stride-2 max-pool unit.
module maxpool_scheduler #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IMG_SIZE   = 100,
    parameter int unsigned MAX_CH     = 64,
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned WR_LAT     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [$clog2(MAX_CH+1)-1:0]    num_ch,
    input  logic [ADDR_WIDTH-1:0]          in_base,
    input  logic [ADDR_WIDTH-1:0]          out_base,
    input  logic                           hold,
    output logic                           busy,
    output logic                           done,
    output logic                           rd_en,
    output logic [ADDR_WIDTH-1:0]          rd_addr,
    input  logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           pool_valid_in,
    output logic [DATA_WIDTH-1:0]          pool_data_in,
    output logic                           pool_clr,
    input  logic [DATA_WIDTH-1:0]          pool_data_out,
    output logic                           wr_en,
    output logic [ADDR_WIDTH-1:0]          wr_addr,
    output logic [DATA_WIDTH-1:0]          wr_data
);

    import pool_pkg::*;

    localparam int unsigned NUM_CH_W = ch_width(MAX_CH);
    localparam int unsigned RC_W     = $clog2(IMG_SIZE);
    localparam int unsigned DL_W     = WR_LAT + 1;

    localparam logic [ADDR_WIDTH-1:0] IN_STRIDE  = ADDR_WIDTH'(plane_words(IMG_SIZE));
    localparam logic [ADDR_WIDTH-1:0] OUT_STRIDE = ADDR_WIDTH'(out_plane_words(IMG_SIZE));

    state_t                state;
    logic [NUM_CH_W-1:0]   num_ch_q;
    logic [NUM_CH_W-1:0]   ch;
    logic [ADDR_WIDTH-1:0] in_plane;
    logic [ADDR_WIDTH-1:0] out_plane;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [DL_W-1:0]       dl;
    logic [DL_W-1:0]       dl_shift;
    logic                  rd_issue;
    logic                  rc_clr;
    logic                  last_px;
    logic                  odd_odd;
    logic                  drain_done;
    logic [RC_W-1:0]       row;
    logic [RC_W-1:0]       col;
    logic                  unused_rc;

    // A read goes out every STREAM cycle the memory is not stalled.
    assign rd_issue = (state == ST_STREAM) && !hold;
    assign rc_clr   = (state == ST_CLEAR);
    assign rd_en    = rd_issue;
    assign rd_addr  = rd_ptr;

    // The last write of a channel is in the final delay stage once all earlier stages are empty.
    assign dl_shift   = dl << 1;
    assign drain_done = (dl_shift == '0);

    // Memory and pool data arrive already registered and aligned with their strobes.
    assign pool_data_in = pool_valid_in ? rd_data : '0;
    assign wr_en        = dl[DL_W-1];
    assign wr_addr      = wr_ptr;
    assign wr_data      = wr_en ? pool_data_out : '0;

    // Position within the plane; row/col are kept for schedulers that need them.
    assign unused_rc = ^{row, col};

    raster_counter #(
        .SIZE (IMG_SIZE),
        .W    (RC_W)
    ) u_raster (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (rd_issue),
        .clr     (rc_clr),
        .row     (row),
        .col     (col),
        .last    (last_px),
        .odd_odd (odd_odd)
    );

    // Scheduler FSM with registered control outputs and plane-base accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pool_clr  <= 1'b0;
            num_ch_q  <= '0;
            ch        <= '0;
            in_plane  <= '0;
            out_plane <= '0;
            rd_ptr    <= '0;
        end else begin
            done     <= 1'b0;
            pool_clr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !done) begin
                        if (num_ch == '0) begin
                            state <= ST_DONE;
                        end else begin
                            num_ch_q  <= num_ch;
                            ch        <= '0;
                            in_plane  <= in_base;
                            out_plane <= out_base;
                            busy      <= 1'b1;
                            pool_clr  <= 1'b1;
                            state     <= ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: begin
                    rd_ptr <= in_plane;
                    state  <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (rd_issue) begin
                        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                        if (last_px) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    in_plane  <= in_plane + IN_STRIDE;
                    out_plane <= out_plane + OUT_STRIDE;
                    if ((ch + NUM_CH_W'(1)) == num_ch_q) begin
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        ch       <= ch + NUM_CH_W'(1);
                        pool_clr <= 1'b1;
                        state    <= ST_CLEAR;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pool strobe, window-completion delay line and packed output pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pool_valid_in <= 1'b0;
            dl            <= '0;
            wr_ptr        <= '0;
        end else begin
            pool_valid_in <= rd_issue;
            dl            <= dl_shift | DL_W'(rd_issue & odd_odd);
            if (state == ST_CLEAR) begin
                wr_ptr <= out_plane;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
        end
    end

endmodule
